// File: rtl/rv32_pkg.sv
// Shared RV32I machine-mode trap definitions. These are the FSM state encodings,
// the PC source selects, the mcause codes and the system-instruction field values.
package rv32_pkg;

  typedef enum logic [1:0] {
    ST_RESET       = 2'b00,
    ST_OPERATING   = 2'b01,
    ST_TRAP_TAKEN  = 2'b10,
    ST_TRAP_RETURN = 2'b11
  } trap_state_t;

  localparam logic [1:0] PC_SRC_BOOT = 2'b00;
  localparam logic [1:0] PC_SRC_MEPC = 2'b01;
  localparam logic [1:0] PC_SRC_TRAP = 2'b10;
  localparam logic [1:0] PC_SRC_NEXT = 2'b11;

  localparam logic [3:0] CAUSE_INSTR_MISALIGNED = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL_INSTR    = 4'd2;
  localparam logic [3:0] CAUSE_BREAKPOINT       = 4'd3;
  localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
  localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;
  localparam logic [3:0] CAUSE_ECALL_M          = 4'd11;
  localparam logic [3:0] CAUSE_M_SW_IRQ         = 4'd3;
  localparam logic [3:0] CAUSE_M_TIMER_IRQ      = 4'd7;
  localparam logic [3:0] CAUSE_M_EXT_IRQ        = 4'd11;

  localparam logic [4:0] OPC_SYSTEM    = 5'b11100;
  localparam logic [2:0] FUNCT3_PRIV   = 3'b000;
  localparam logic [6:0] FUNCT7_ECALL  = 7'b0000000;
  localparam logic [4:0] RS2_ECALL     = 5'b00000;
  localparam logic [6:0] FUNCT7_EBREAK = 7'b0000000;
  localparam logic [4:0] RS2_EBREAK    = 5'b00001;
  localparam logic [6:0] FUNCT7_MRET   = 7'b0011000;
  localparam logic [4:0] RS2_MRET      = 5'b00010;

endpackage

// File: rtl/trap_priority_enc.sv
// Combinational trap priority encoder. It selects the winning exception or qualified
// interrupt and reports it as {valid, i_or_e, cause}.
module trap_priority_enc
  import rv32_pkg::*;
(
  input  logic       illegal_instr,
  input  logic       misaligned_instr,
  input  logic       ecall,
  input  logic       ebreak,
  input  logic       misaligned_load,
  input  logic       misaligned_store,
  input  logic       ext_irq,
  input  logic       sw_irq,
  input  logic       timer_irq,
  output logic       valid,
  output logic       i_or_e,
  output logic [3:0] cause
);

  // Exceptions are checked before interrupts.
  always_comb begin
    valid  = 1'b1;
    i_or_e = 1'b0;
    cause  = 4'd0;
    if (illegal_instr) begin
      cause = CAUSE_ILLEGAL_INSTR;
    end else if (misaligned_instr) begin
      cause = CAUSE_INSTR_MISALIGNED;
    end else if (ecall) begin
      cause = CAUSE_ECALL_M;
    end else if (ebreak) begin
      cause = CAUSE_BREAKPOINT;
    end else if (misaligned_load) begin
      cause = CAUSE_LOAD_MISALIGNED;
    end else if (misaligned_store) begin
      cause = CAUSE_STORE_MISALIGNED;
    end else if (ext_irq) begin
      i_or_e = 1'b1;
      cause  = CAUSE_M_EXT_IRQ;
    end else if (sw_irq) begin
      i_or_e = 1'b1;
      cause  = CAUSE_M_SW_IRQ;
    end else if (timer_irq) begin
      i_or_e = 1'b1;
      cause  = CAUSE_M_TIMER_IRQ;
    end else begin
      valid = 1'b0;
    end
  end

endmodule

// File: rtl/machine_trap_control.sv
// Machine-mode trap sequencer. It decides trap entry and mret return, selects the PC
// source and strobes the CSR file.
module machine_trap_control
  import rv32_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = 1
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       illegal_instr_in,
  input  logic       misaligned_load_in,
  input  logic       misaligned_store_in,
  input  logic       misaligned_instr_in,
  input  logic [4:0] opcode_6_to_2_in,
  input  logic [2:0] funct3_in,
  input  logic [6:0] funct7_in,
  input  logic [4:0] rs1_addr_in,
  input  logic [4:0] rs2_addr_in,
  input  logic [4:0] rd_addr_in,
  input  logic       mie_in,
  input  logic       meie_in,
  input  logic       mtie_in,
  input  logic       msie_in,
  input  logic       meip_in,
  input  logic       mtip_in,
  input  logic       msip_in,
  output logic [1:0] pc_src_out,
  output logic       flush_out,
  output logic       trap_taken_out,
  output logic       instret_inc_out,
  output logic       set_cause_out,
  output logic       set_epc_out,
  output logic       i_or_e_out,
  output logic [3:0] cause_out,
  output logic       mie_clear_out,
  output logic       mie_set_out
);

  localparam logic [3:0] RESET_LAST = 4'(RESET_CYCLES - 1);

  trap_state_t state_r;
  trap_state_t state_next_s;
  logic [3:0]  rst_cnt_r;
  logic        i_or_e_r;
  logic [3:0]  cause_r;

  logic        sys_s;
  logic        ecall_s;
  logic        ebreak_s;
  logic        mret_s;
  logic        win_valid_s;
  logic        win_i_or_e_s;
  logic [3:0]  win_cause_s;
  logic        in_operating_s;

  assign sys_s    = (opcode_6_to_2_in == OPC_SYSTEM) && (funct3_in == FUNCT3_PRIV) &&
                    (rs1_addr_in == 5'd0) && (rd_addr_in == 5'd0);
  assign ecall_s  = sys_s && (funct7_in == FUNCT7_ECALL)  && (rs2_addr_in == RS2_ECALL);
  assign ebreak_s = sys_s && (funct7_in == FUNCT7_EBREAK) && (rs2_addr_in == RS2_EBREAK);
  assign mret_s   = sys_s && (funct7_in == FUNCT7_MRET)   && (rs2_addr_in == RS2_MRET);

  trap_priority_enc u_prio (
    .illegal_instr    (illegal_instr_in),
    .misaligned_instr (misaligned_instr_in),
    .ecall            (ecall_s),
    .ebreak           (ebreak_s),
    .misaligned_load  (misaligned_load_in),
    .misaligned_store (misaligned_store_in),
    .ext_irq          (mie_in & meie_in & meip_in),
    .sw_irq           (mie_in & msie_in & msip_in),
    .timer_irq        (mie_in & mtie_in & mtip_in),
    .valid            (win_valid_s),
    .i_or_e           (win_i_or_e_s),
    .cause            (win_cause_s)
  );

  assign in_operating_s  = (state_r == ST_OPERATING);
  assign trap_taken_out  = in_operating_s & win_valid_s;
  assign instret_inc_out = in_operating_s & ~win_valid_s & ~mret_s;
  assign i_or_e_out      = i_or_e_r;
  assign cause_out       = cause_r;

  // State register and reset-hold counter.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r   <= ST_RESET;
      rst_cnt_r <= 4'd0;
    end else begin
      state_r <= state_next_s;
      if (state_r == ST_RESET && rst_cnt_r != RESET_LAST) begin
        rst_cnt_r <= rst_cnt_r + 4'd1;
      end else begin
        rst_cnt_r <= 4'd0;
      end
    end
  end

  // Cause register latches only on trap entry.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      i_or_e_r <= 1'b0;
      cause_r  <= 4'd0;
    end else if (trap_taken_out) begin
      i_or_e_r <= win_i_or_e_s;
      cause_r  <= win_cause_s;
    end else begin
      i_or_e_r <= i_or_e_r;
      cause_r  <= cause_r;
    end
  end

  // Next-state logic; a trap outranks mret in OPERATING.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_RESET: begin
        if (rst_cnt_r == RESET_LAST) begin
          state_next_s = ST_OPERATING;
        end else begin
          state_next_s = ST_RESET;
        end
      end
      ST_OPERATING: begin
        if (trap_taken_out) begin
          state_next_s = ST_TRAP_TAKEN;
        end else if (mret_s) begin
          state_next_s = ST_TRAP_RETURN;
        end else begin
          state_next_s = ST_OPERATING;
        end
      end
      ST_TRAP_TAKEN:  state_next_s = ST_OPERATING;
      ST_TRAP_RETURN: state_next_s = ST_OPERATING;
      default:        state_next_s = ST_RESET;
    endcase
  end

  // Moore output decode.
  always_comb begin
    pc_src_out    = PC_SRC_BOOT;
    flush_out     = 1'b1;
    set_cause_out = 1'b0;
    set_epc_out   = 1'b0;
    mie_clear_out = 1'b0;
    mie_set_out   = 1'b0;
    case (state_r)
      ST_RESET: begin
        pc_src_out = PC_SRC_BOOT;
        flush_out  = 1'b1;
      end
      ST_OPERATING: begin
        pc_src_out = PC_SRC_NEXT;
        flush_out  = 1'b0;
      end
      ST_TRAP_TAKEN: begin
        pc_src_out    = PC_SRC_TRAP;
        flush_out     = 1'b1;
        set_cause_out = 1'b1;
        set_epc_out   = 1'b1;
        mie_clear_out = 1'b1;
      end
      ST_TRAP_RETURN: begin
        pc_src_out  = PC_SRC_MEPC;
        flush_out   = 1'b1;
        mie_set_out = 1'b1;
      end
      default: begin
        pc_src_out = PC_SRC_BOOT;
        flush_out  = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_machine_trap_control.sv
// Self-checking bench for machine_trap_control. It runs directed scenarios followed
// by random stimulus, all checked against a cycle-level behavioural model of the trap rules.
module tb_machine_trap_control;

  localparam int RC = 1;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       illegal_instr_in, misaligned_load_in, misaligned_store_in, misaligned_instr_in;
  logic [4:0] opcode_6_to_2_in;
  logic [2:0] funct3_in;
  logic [6:0] funct7_in;
  logic [4:0] rs1_addr_in, rs2_addr_in, rd_addr_in;
  logic       mie_in, meie_in, mtie_in, msie_in, meip_in, mtip_in, msip_in;
  logic [1:0] pc_src_out;
  logic       flush_out, trap_taken_out, instret_inc_out, set_cause_out, set_epc_out;
  logic       i_or_e_out, mie_clear_out, mie_set_out;
  logic [3:0] cause_out;

  int checks = 0;
  int failures = 0;

  // Model: remaining reset cycles, and what the previous edge started (0 none, 1 trap, 2 return)
  int         m_reset_left;
  int         m_event;
  logic [3:0] m_cause;
  logic       m_ie;

  machine_trap_control #(.RESET_CYCLES(RC)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .illegal_instr_in(illegal_instr_in), .misaligned_load_in(misaligned_load_in),
    .misaligned_store_in(misaligned_store_in), .misaligned_instr_in(misaligned_instr_in),
    .opcode_6_to_2_in(opcode_6_to_2_in), .funct3_in(funct3_in), .funct7_in(funct7_in),
    .rs1_addr_in(rs1_addr_in), .rs2_addr_in(rs2_addr_in), .rd_addr_in(rd_addr_in),
    .mie_in(mie_in), .meie_in(meie_in), .mtie_in(mtie_in), .msie_in(msie_in),
    .meip_in(meip_in), .mtip_in(mtip_in), .msip_in(msip_in),
    .pc_src_out(pc_src_out), .flush_out(flush_out), .trap_taken_out(trap_taken_out),
    .instret_inc_out(instret_inc_out), .set_cause_out(set_cause_out),
    .set_epc_out(set_epc_out), .i_or_e_out(i_or_e_out), .cause_out(cause_out),
    .mie_clear_out(mie_clear_out), .mie_set_out(mie_set_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    illegal_instr_in = 1'b0; misaligned_load_in = 1'b0;
    misaligned_store_in = 1'b0; misaligned_instr_in = 1'b0;
    opcode_6_to_2_in = 5'b01100; funct3_in = 3'd0; funct7_in = 7'd0;
    rs1_addr_in = 5'd1; rs2_addr_in = 5'd2; rd_addr_in = 5'd3;
    mie_in = 1'b0; meie_in = 1'b0; mtie_in = 1'b0; msie_in = 1'b0;
    meip_in = 1'b0; mtip_in = 1'b0; msip_in = 1'b0;
  endtask

  // kind: 0 ecall, 1 ebreak, 2 mret
  task automatic sys_instr(input int kind);
    opcode_6_to_2_in = 5'b11100; funct3_in = 3'd0; rs1_addr_in = 5'd0; rd_addr_in = 5'd0;
    funct7_in   = (kind == 2) ? 7'b0011000 : 7'd0;
    rs2_addr_in = (kind == 2) ? 5'b00010 : ((kind == 1) ? 5'd1 : 5'd0);
  endtask

  // Evaluate the trap rules on the present inputs.
  task automatic eval(output bit trap, output bit mret, output logic [4:0] win);
    bit   sys;
    bit   exc [6];
    int   exc_code [6] = '{2, 0, 11, 3, 4, 6};
    bit   irq [3];
    int   irq_code [3] = '{11, 3, 7};
    bit   running;
    sys = (opcode_6_to_2_in == 5'b11100) && (funct3_in == 3'd0) &&
          (rs1_addr_in == 5'd0) && (rd_addr_in == 5'd0);
    exc[0] = illegal_instr_in;
    exc[1] = misaligned_instr_in;
    exc[2] = sys && funct7_in == 7'd0 && rs2_addr_in == 5'd0;
    exc[3] = sys && funct7_in == 7'd0 && rs2_addr_in == 5'd1;
    exc[4] = misaligned_load_in;
    exc[5] = misaligned_store_in;
    irq[0] = mie_in && meie_in && meip_in;
    irq[1] = mie_in && msie_in && msip_in;
    irq[2] = mie_in && mtie_in && mtip_in;
    running = (m_reset_left == 0) && (m_event == 0);
    mret = sys && funct7_in == 7'b0011000 && rs2_addr_in == 5'b00010;
    trap = 1'b0;
    win  = 5'd0;
    for (int i = 5; i >= 0; i--) if (exc[i]) win = {1'b0, 4'(exc_code[i])};
    if (win == 5'd0 && !exc[1]) begin
      for (int i = 2; i >= 0; i--) if (irq[i]) win = {1'b1, 4'(irq_code[i])};
    end
    trap = running && (exc[0] || exc[1] || exc[2] || exc[3] || exc[4] || exc[5] ||
                       irq[0] || irq[1] || irq[2]);
  endtask

  // Check all outputs for the current cycle, then advance one clock and update the model.
  task automatic tick();
    bit         trap, mret, running;
    logic [4:0] win;
    logic [1:0] exp_pc;
    #1;
    eval(trap, mret, win);
    running = (m_reset_left == 0) && (m_event == 0);
    exp_pc = (m_reset_left > 0) ? 2'b00 : (m_event == 1) ? 2'b10 : (m_event == 2) ? 2'b01 : 2'b11;
    chk("pc_src",      8'(pc_src_out),      8'(exp_pc));
    chk("flush",       8'(flush_out),       8'(!running));
    chk("trap_taken",  8'(trap_taken_out),  8'(trap));
    chk("instret_inc", 8'(instret_inc_out), 8'(running && !trap && !mret));
    chk("set_cause",   8'(set_cause_out),   8'(m_event == 1 && m_reset_left == 0));
    chk("set_epc",     8'(set_epc_out),     8'(m_event == 1 && m_reset_left == 0));
    chk("mie_clear",   8'(mie_clear_out),   8'(m_event == 1 && m_reset_left == 0));
    chk("mie_set",     8'(mie_set_out),     8'(m_event == 2 && m_reset_left == 0));
    chk("cause",       8'(cause_out),       8'(m_cause));
    chk("i_or_e",      8'(i_or_e_out),      8'(m_ie));
    @(posedge clk_in);
    if (rst_in) begin
      m_reset_left = RC; m_event = 0; m_cause = 4'd0; m_ie = 1'b0;
    end else if (m_reset_left > 0) begin
      m_reset_left--;
    end else if (m_event != 0) begin
      m_event = 0;
    end else if (trap) begin
      m_event = 1; m_ie = win[4]; m_cause = win[3:0];
    end else if (mret) begin
      m_event = 2;
    end
    #1;
  endtask

  initial begin
    idle_inputs();
    rst_in = 1'b1;
    m_reset_left = RC; m_event = 0; m_cause = 4'd0; m_ie = 1'b0;
    @(posedge clk_in);
    #1;
    // Reset held for three cycles, then released
    tick(); tick();
    rst_in = 1'b0;
    tick();
    tick();
    chk("op_pc_after_reset", 8'(pc_src_out), 8'd3);

    // Illegal and load-misaligned together: illegal wins
    illegal_instr_in = 1'b1; misaligned_load_in = 1'b1;
    tick();
    idle_inputs();
    tick();
    chk("illegal_cause", 8'(cause_out), 8'd2);
    tick();

    // External and timer pending and enabled: external wins
    mie_in = 1'b1; meie_in = 1'b1; mtie_in = 1'b1; meip_in = 1'b1; mtip_in = 1'b1;
    tick();
    chk("ext_irq_cause", 8'({i_or_e_out, cause_out}), 8'h1b);
    idle_inputs();
    tick();
    // Global disable masks interrupts
    meie_in = 1'b1; mtie_in = 1'b1; meip_in = 1'b1; mtip_in = 1'b1;
    tick();
    idle_inputs();

    // mret
    sys_instr(2);
    tick();
    idle_inputs();
    tick();
    tick();

    // ecall held during TRAP_TAKEN is ignored
    illegal_instr_in = 1'b1;
    tick();
    idle_inputs();
    sys_instr(0);
    tick();
    idle_inputs();
    tick();

    // Reset during TRAP_RETURN
    sys_instr(2);
    tick();
    idle_inputs();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    tick();
    tick();

    // mret with misaligned target, then mret with software interrupt
    sys_instr(2); misaligned_instr_in = 1'b1;
    tick();
    idle_inputs();
    tick();
    chk("mret_misaligned_cause", 8'(cause_out), 8'd0);
    sys_instr(2); mie_in = 1'b1; msie_in = 1'b1; msip_in = 1'b1;
    tick();
    idle_inputs();
    tick();
    tick();

    // Random stimulus
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      idle_inputs();
      rst_in = (r < 2);
      illegal_instr_in    = ($urandom_range(0, 15) == 0);
      misaligned_load_in  = ($urandom_range(0, 15) == 0);
      misaligned_store_in = ($urandom_range(0, 15) == 0);
      misaligned_instr_in = ($urandom_range(0, 15) == 0);
      if (r < 40) begin
        sys_instr(int'($urandom_range(0, 2)));
        if ($urandom_range(0, 7) == 0) rs1_addr_in = 5'($urandom);
        if ($urandom_range(0, 7) == 0) funct3_in = 3'($urandom);
      end else begin
        opcode_6_to_2_in = 5'($urandom); funct3_in = 3'($urandom); funct7_in = 7'($urandom);
        rs1_addr_in = 5'($urandom); rs2_addr_in = 5'($urandom); rd_addr_in = 5'($urandom);
      end
      mie_in  = ($urandom_range(0, 3) != 0);
      meie_in = 1'($urandom); mtie_in = 1'($urandom); msie_in = 1'($urandom);
      meip_in = ($urandom_range(0, 7) == 0);
      mtip_in = ($urandom_range(0, 7) == 0);
      msip_in = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/machine_trap_control.md
# machine_trap_control

Machine-mode trap sequencer for the RV32I core. Sits beside the instruction decoder and consumes its exception flags (illegal instruction, misaligned load/store), plus the instruction-address misalignment, system-instruction fields and interrupt lines. It decides when the core enters or returns from a trap, selects the PC source, and drives the CSR-file update strobes. It also returns `trap_taken_out` to the decoder's `trap_taken_in` so that stores on a trapping instruction are suppressed.

## Interface
- `RESET_CYCLES`, default 1: cycles spent in RESET before OPERATING; range 1–15.
- `clk_in` in 1: core clock; all state changes on rising edge.
- `rst_in` in 1: reset, synchronous, active-high.
- `illegal_instr_in` in 1: decoder illegal-instruction flag.
- `misaligned_load_in` in 1: decoder load misalignment flag.
- `misaligned_store_in` in 1: decoder store misalignment flag.
- `misaligned_instr_in` in 1: branch/jump target not word-aligned.
- `opcode_6_to_2_in` in 5: current instruction opcode[6:2].
- `funct3_in` in 3: instruction funct3.
- `funct7_in` in 7: instruction funct7.
- `rs1_addr_in`, `rs2_addr_in`, `rd_addr_in` in 5 each: register fields.
- `mie_in` in 1: mstatus.MIE global enable.
- `meie_in`, `mtie_in`, `msie_in` in 1 each: mie enable bits.
- `meip_in`, `mtip_in`, `msip_in` in 1 each: pending external, timer and software interrupts.
- `pc_src_out` out 2: 00 boot address, 01 mepc, 10 trap vector, 11 next PC.
- `flush_out` out 1: kill the instruction in flight.
- `trap_taken_out` out 1: trap condition detected this cycle.
- `instret_inc_out` out 1: retire strobe for minstret.
- `set_cause_out` out 1: write mcause.
- `set_epc_out` out 1: write mepc.
- `i_or_e_out` out 1: mcause interrupt bit (1 = interrupt).
- `cause_out` out 4: mcause exception code.
- `mie_clear_out` out 1: save MIE→MPIE and clear MIE.
- `mie_set_out` out 1: restore MIE←MPIE.

## Operation
- System decode applies only when opcode = 11100, funct3 = 000, rs1 = rd = 0.
  - ecall: funct7 = 0 and rs2 = 0.
  - ebreak: funct7 = 0 and rs2 = 1.
  - mret: funct7 = 0011000 and rs2 = 00010.
- Exception priority, highest first:
  - illegal (2)
  - instr misaligned (0)
  - ecall (11)
  - ebreak (3)
  - load misaligned (4)
  - store misaligned (6)
- Interrupts qualify only when `mie_in` = 1 and the matching enable is 1. Interrupt priority: external (11) > software (3) > timer (7). Exceptions always beat interrupts.
- `trap_taken_out` = OPERATING & (any exception | any qualified interrupt). It is combinational.
- FSM states are RESET, OPERATING, TRAP_TAKEN, TRAP_RETURN.
  - RESET: counts `RESET_CYCLES`, then → OPERATING.
  - OPERATING: → TRAP_TAKEN if `trap_taken_out`; else → TRAP_RETURN if mret; else stays.
  - TRAP_TAKEN → OPERATING.
  - TRAP_RETURN → OPERATING.
- Cause register: on the OPERATING→TRAP_TAKEN edge, {`i_or_e_out`, `cause_out`} latch the winning cause. Otherwise they hold.
- Outputs are Moore, decoded from state, except `trap_taken_out` and `instret_inc_out`.
  - RESET: `pc_src_out` = 00, flush 1, all strobes 0.
  - OPERATING: `pc_src_out` = 11, flush 0. `instret_inc_out` = 1 when not `trap_taken_out` and not mret.
  - TRAP_TAKEN: `pc_src_out` = 10, flush 1. `set_cause_out`, `set_epc_out` and `mie_clear_out` = 1.
  - TRAP_RETURN: `pc_src_out` = 01, flush 1, `mie_set_out` = 1.
- Reset values: state RESET, counter 0, `cause_out` 0, `i_or_e_out` 0, `pc_src_out` 00, `flush_out` 1. All other outputs 0.

## Timing
- Trap detected in cycle N. TRAP_TAKEN strobes and the vector PC appear in cycle N+1. Fetch resumes in OPERATING at cycle N+2.
- mret in cycle N. `pc_src_out` = 01 and `mie_set_out` appear in cycle N+1. OPERATING at N+2.
- Conditions present while in TRAP_TAKEN or TRAP_RETURN are ignored. Interrupts still pending are re-evaluated in OPERATING.
- Simultaneous mret and exception: the exception wins. Example: mret with a misaligned target gives TRAP_TAKEN, cause 0.
- Simultaneous mret and interrupt: the interrupt wins.
- `rst_in` high in any state: next state RESET, counter cleared, outputs at reset values from the next edge. Reset beats every trap condition.
- Each strobe is high for exactly one cycle per trap or return.

## Structure
- Shared package `rv32_pkg` holds:
  - state encodings (2-bit);
  - `PC_SRC_*` constants;
  - mcause codes `CAUSE_*`;
  - `OPC_SYSTEM` = 11100;
  - funct7/rs2 values for mret, ecall and ebreak.
- Sub-module `trap_priority_enc` is combinational. It takes the exception flags and qualified interrupts and produces {valid, i_or_e, cause[3:0]}.
- The FSM, reset counter and cause register live in `machine_trap_control`.

## Test plan
- Reset: `rst_in` held 3 cycles, then released with `RESET_CYCLES` = 1 → `pc_src_out` 00 and flush 1 for 1 cycle after release, then 11.
- Illegal + load misaligned in the same cycle → next cycle TRAP_TAKEN with cause 2, i_or_e 0, set_cause/set_epc/mie_clear high for 1 cycle, `pc_src_out` 10.
- `meip_in` = `mtip_in` = 1, `mie_in` = `meie_in` = `mtie_in` = 1 → cause 11, i_or_e 1. Repeat with `mie_in` = 0 → no trap, `instret_inc_out` 1.
- mret (funct7 0011000, rs2 00010) → `pc_src_out` 01 and `mie_set_out` 1 for one cycle, then OPERATING.
- ecall asserted while in TRAP_TAKEN → ignored. `rst_in` asserted in TRAP_RETURN → RESET next cycle, `cause_out` 0.
